// File: rtl/bf_program_loader.sv
// Brainfuck source loader: filters command characters from a byte stream, encodes
// them as 3-bit opcodes into program RAM, appends a halt word and checks nesting/length.
module bf_program_loader #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        char_data,
  input  logic              char_valid,
  input  logic              char_last,
  output logic              char_ready,
  output logic              prg_we,
  output logic [ADDR_W-1:0] prg_addr,
  output logic [WIDTH-1:0]  prg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] length
);

  typedef enum logic [1:0] {IDLE, LOAD, TERM} state_t;

  localparam logic [ADDR_W-1:0]  PTR_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [WIDTH-1:0]   HALT     = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt, length_nxt, addr_nxt;
  logic [DEPTH_W-1:0]  depth, depth_nxt;
  logic [WIDTH-1:0]    data_nxt;
  logic [1:0]          code_nxt;
  logic                we_nxt, done_nxt, error_nxt;
  logic                is_cmd;
  logic [2:0]          op;

  always_comb begin
    is_cmd = 1'b1;
    op     = 3'b000;
    case (char_data)
      8'h3E: op = 3'b000;  // >
      8'h3C: op = 3'b001;  // <
      8'h2B: op = 3'b010;  // +
      8'h2D: op = 3'b011;  // -
      8'h5B: op = 3'b100;  // [
      8'h5D: op = 3'b101;  // ]
      8'h2C: op = 3'b110;  // ,
      8'h2E: op = 3'b111;  // .
      default: is_cmd = 1'b0;
    endcase
  end

  assign char_ready = (state == LOAD);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    depth_nxt  = depth;
    length_nxt = length;
    error_nxt  = error;
    code_nxt   = err_code;
    we_nxt     = 1'b0;
    addr_nxt   = prg_addr;
    data_nxt   = prg_data;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (start) begin
        ptr_nxt    = '0;
        depth_nxt  = '0;
        length_nxt = '0;
        error_nxt  = 1'b0;
        code_nxt   = 2'b00;
        state_nxt  = LOAD;
      end
      LOAD: if (char_valid) begin
        // Unmatched ']' outranks overflow when both apply to the same character.
        if (is_cmd && op == 3'b101 && depth == '0) begin
          error_nxt = 1'b1;
          code_nxt  = 2'b01;
          state_nxt = IDLE;
        end else if (is_cmd && ((op == 3'b100 && depth == DEPTH_MAX) || ptr == PTR_MAX)) begin
          error_nxt = 1'b1;
          code_nxt  = 2'b11;
          state_nxt = IDLE;
        end else begin
          if (is_cmd) begin
            we_nxt   = 1'b1;
            addr_nxt = ptr;
            data_nxt = {{(WIDTH-3){1'b0}}, op};
            ptr_nxt  = ptr + 1'b1;
            if (op == 3'b100) depth_nxt = depth + 1'b1;
            if (op == 3'b101) depth_nxt = depth - 1'b1;
          end
          if (char_last) state_nxt = TERM;
        end
      end
      TERM: begin
        state_nxt = IDLE;
        if (depth != '0) begin
          error_nxt = 1'b1;
          code_nxt  = 2'b10;
        end else begin
          we_nxt     = 1'b1;
          addr_nxt   = ptr;
          data_nxt   = HALT;
          length_nxt = ptr;
          done_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      depth    <= '0;
      length   <= '0;
      error    <= 1'b0;
      err_code <= 2'b00;
      prg_we   <= 1'b0;
      prg_addr <= '0;
      prg_data <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      depth    <= depth_nxt;
      length   <= length_nxt;
      error    <= error_nxt;
      err_code <= code_nxt;
      prg_we   <= we_nxt;
      prg_addr <= addr_nxt;
      prg_data <= data_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench: default loader plus short-address (ADDR_W=2) and shallow-nesting
// (DEPTH_W=2) variants sharing one stimulus stream.
module tb_bf_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cdata = 8'h00;
  logic       cvalid = 1'b0;
  logic       clast = 1'b0;

  logic       rdy0, we0, busy0, done0, err0;
  logic [7:0] addr0, data0, len0;
  logic [1:0] code0;
  logic       rdy1, we1, busy1, done1, err1;
  logic [1:0] addr1, len1, code1;
  logic [7:0] data1;
  logic       rdy2, we2, busy2, done2, err2;
  logic [7:0] addr2, data2, len2;
  logic [1:0] code2;

  int ncmp = 0;
  int nerr = 0;
  int nd0 = 0;
  int nd1 = 0;
  logic [15:0] wl0[$];
  logic [15:0] wl1[$];
  logic [15:0] wl2[$];

  always #5 clk = ~clk;

  bf_program_loader #(.WIDTH(8), .ADDR_W(8), .DEPTH_W(4)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .char_data(cdata), .char_valid(cvalid),
    .char_last(clast), .char_ready(rdy0), .prg_we(we0), .prg_addr(addr0), .prg_data(data0),
    .busy(busy0), .done(done0), .error(err0), .err_code(code0), .length(len0));

  bf_program_loader #(.WIDTH(8), .ADDR_W(2), .DEPTH_W(4)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .char_data(cdata), .char_valid(cvalid),
    .char_last(clast), .char_ready(rdy1), .prg_we(we1), .prg_addr(addr1), .prg_data(data1),
    .busy(busy1), .done(done1), .error(err1), .err_code(code1), .length(len1));

  bf_program_loader #(.WIDTH(8), .ADDR_W(8), .DEPTH_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .char_data(cdata), .char_valid(cvalid),
    .char_last(clast), .char_ready(rdy2), .prg_we(we2), .prg_addr(addr2), .prg_data(data2),
    .busy(busy2), .done(done2), .error(err2), .err_code(code2), .length(len2));

  always @(negedge clk) begin
    if (we0) wl0.push_back({addr0, data0});
    if (we1) wl1.push_back({6'd0, addr1, data1});
    if (we2) wl2.push_back({addr2, data2});
    if (done0) nd0++;
    if (done1) nd1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wl_at(input int which, input int i);
    logic [15:0] r;
    r = 16'hxxxx;
    case (which)
      0: if (i < wl0.size()) r = wl0[i];
      1: if (i < wl1.size()) r = wl1[i];
      default: if (i < wl2.size()) r = wl2[i];
    endcase
    return r;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      cdata  = s[i];
      cvalid = 1'b1;
      clast  = last && (i == s.len() - 1);
    end
    @(negedge clk);
    cvalid = 1'b0;
    clast  = 1'b0;
  endtask

  task automatic clr();
    wl0.delete(); wl1.delete(); wl2.delete();
    nd0 = 0; nd1 = 0;
  endtask

  logic [7:0] exp1[9] = '{8'h02, 8'h04, 8'h03, 8'h00, 8'h02, 8'h01, 8'h05, 8'h07, 8'h80};
  logic [7:0] exp4[4] = '{8'h04, 8'h04, 8'h02, 8'h05};

  initial begin
    #3;
    chk("rst_ready", rdy0, 0);
    chk("rst_we", we0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_error", err0, 0);
    chk("rst_code", code0, 0);
    chk("rst_len", len0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", rdy0, 0);

    // Full program with nesting
    clr();
    do_start();
    chk("t1_ready", rdy0, 1);
    chk("t1_busy", busy0, 1);
    send("+[->+<].", 1'b1);
    chk("t1_term_ready", rdy0, 0);
    chk("t1_term_busy", busy0, 1);
    repeat (3) @(negedge clk);
    chk("t1_nwr", wl0.size(), 9);
    for (int i = 0; i < 9; i++) chk("t1_wr", wl_at(0, i), {8'(i), exp1[i]});
    chk("t1_done", nd0, 1);
    chk("t1_len", len0, 8);
    chk("t1_err", err0, 0);
    chk("t1_busy_end", busy0, 0);

    // Comments are dropped
    clr();
    do_start();
    send("a+ b\n-", 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_nwr", wl0.size(), 3);
    chk("t2_wr0", wl_at(0, 0), 16'h0002);
    chk("t2_wr1", wl_at(0, 1), 16'h0103);
    chk("t2_wr2", wl_at(0, 2), 16'h0280);
    chk("t2_len", len0, 2);
    chk("t2_done", nd0, 1);

    // Unmatched ']'
    clr();
    do_start();
    send("+]", 1'b1);
    chk("t3_err", err0, 1);
    chk("t3_code", code0, 1);
    chk("t3_busy", busy0, 0);
    chk("t3_ready", rdy0, 0);
    chk("t3_we", we0, 0);
    repeat (3) @(negedge clk);
    chk("t3_nwr", wl0.size(), 1);
    chk("t3_wr0", wl_at(0, 0), 16'h0002);
    chk("t3_done", nd0, 0);
    chk("t3_sticky", err0, 1);
    do_start();
    chk("t3_clr_err", err0, 0);
    chk("t3_clr_code", code0, 0);

    // Unmatched '[' at end (loader already in LOAD from previous start)
    clr();
    send("[[+]", 1'b1);
    chk("t4_err_n1", err0, 0);
    chk("t4_busy_n1", busy0, 1);
    @(negedge clk);
    chk("t4_err", err0, 1);
    chk("t4_code", code0, 2);
    chk("t4_busy", busy0, 0);
    repeat (2) @(negedge clk);
    chk("t4_nwr", wl0.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_wr", wl_at(0, i), {8'(i), exp4[i]});
    chk("t4_done", nd0, 0);

    // Address overflow on the ADDR_W=2 instance
    clr();
    do_start();
    send("++++", 1'b0);
    chk("t5_err", err1, 1);
    chk("t5_code", code1, 3);
    chk("t5_busy", busy1, 0);
    repeat (2) @(negedge clk);
    chk("t5_nwr", wl1.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_wr", wl_at(1, i), {8'(i), 8'h02});
    clr();
    do_start();
    send("+++", 1'b1);
    repeat (3) @(negedge clk);
    chk("t5b_nwr", wl1.size(), 4);
    chk("t5b_halt", wl_at(1, 3), 16'h0380);
    chk("t5b_len", len1, 3);
    chk("t5b_done", nd1, 1);
    chk("t5b_err", err1, 0);

    // Depth overflow on the DEPTH_W=2 instance
    clr();
    do_start();
    send("[[[[", 1'b0);
    chk("t6_err", err2, 1);
    chk("t6_code", code2, 3);
    repeat (2) @(negedge clk);
    chk("t6_nwr", wl2.size(), 3);
    for (int i = 0; i < 3; i++) chk("t6_wr", wl_at(2, i), {8'(i), 8'h04});

    // Valid gaps and reset mid-load
    clr();
    do_start();
    chk("t7_clr_err", err2, 0);
    @(negedge clk); cdata = "+"; cvalid = 1'b1;
    @(negedge clk); cvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_gap_nwr", wl2.size(), 1);
    @(negedge clk); cvalid = 1'b1;
    @(negedge clk); cvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_we", we2, 0);
    chk("t7_addr", addr2, 0);
    chk("t7_data", data2, 0);
    chk("t7_ready", rdy2, 0);
    chk("t7_busy", busy2, 0);
    chk("t7_done", done2, 0);
    chk("t7_err", err2, 0);
    chk("t7_code", code2, 0);
    chk("t7_len", len2, 0);
    chk("t7_len0", len0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_nwr", wl2.size(), 2);
    chk("t7_busy_end", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
